// File: rtl/ysyx_25030081_imm_pkg.sv
// Shared definitions for the pipelined immediate generator.
//   - IMM_* : format-select encodings carried on in_op
//   - XLEN_DEFAULT : default datapath width
//   - shamt_width() : shift-amount field width for a given XLEN
package ysyx_25030081_imm_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;

   localparam logic [2:0] IMM_I   = 3'b000;
   localparam logic [2:0] IMM_S   = 3'b001;
   localparam logic [2:0] IMM_B   = 3'b010;
   localparam logic [2:0] IMM_U   = 3'b011;
   localparam logic [2:0] IMM_J   = 3'b100;
   localparam logic [2:0] IMM_Z   = 3'b101;
   localparam logic [2:0] IMM_SH  = 3'b110;
   localparam logic [2:0] IMM_RSV = 3'b111;

   // RV64 shifts use a 6-bit shamt, RV32 a 5-bit one.
   function automatic int unsigned shamt_width(input int unsigned xlen);
      return (xlen == 64) ? 6 : 5;
   endfunction

endpackage

// File: rtl/ysyx_25030081_imm_sel.sv
// Combinational immediate decoder: picks the immediate field for the selected
// format and sign- or zero-extends it to XLEN.
// Ports:
//   inst    [31:0]      raw instruction word
//   op      [2:0]       format select (IMM_*)
//   imm     [XLEN-1:0]  extended immediate (0 for the reserved format)
//   illegal             op was the reserved encoding
module ysyx_25030081_imm_sel
   import ysyx_25030081_imm_pkg::*;
#(
   parameter int unsigned XLEN    = XLEN_DEFAULT,
   parameter int unsigned SHAMT_W = shamt_width(XLEN)
) (
   input  logic [31:0]     inst,
   input  logic [2:0]      op,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   // Opcode bits never feed an immediate field.
   logic unused_opcode;
   assign unused_opcode = ^inst[6:0];

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = '0;
      r[31:0] = v;
      return r;
   endfunction

   always_comb begin
      imm     = '0;
      illegal = 1'b0;
      case (op)
         IMM_I:  imm = sext32({{20{inst[31]}}, inst[31:20]});
         IMM_S:  imm = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
         IMM_B:  imm = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                               inst[11:8], 1'b0});
         IMM_U:  imm = sext32({inst[31:12], 12'b0});
         IMM_J:  imm = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                               inst[30:21], 1'b0});
         IMM_Z:  imm = zext32({27'b0, inst[19:15]});
         IMM_SH: imm = zext32(32'(inst[20 +: SHAMT_W]));
         default: begin
            imm     = '0;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator with valid/ready handshakes.
//   S1 holds the decoded immediate, PC and illegal flag; S2 holds the output
//   registers and adds pc+imm. A result appears two cycles after its input is
//   presented, one result per cycle, at most two entries in flight.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous kill of both stages
//   in_valid/in_ready   upstream handshake
//   in_inst, in_pc      instruction word and its PC
//   in_op               format select (IMM_*)
//   out_valid/out_ready downstream handshake
//   out_imm, out_target extended immediate and pc+imm (mod 2^XLEN)
//   out_pc, out_illegal PC passed through, reserved-format flag
module imm_gen_pipe
   import ysyx_25030081_imm_pkg::*;
#(
   parameter int unsigned XLEN    = XLEN_DEFAULT,
   parameter int unsigned SHAMT_W = shamt_width(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic [2:0]      in_op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_target,
   output logic [XLEN-1:0] out_pc,
   output logic            out_illegal
);

   logic [XLEN-1:0] dec_imm;
   logic            dec_illegal;

   logic            s1_v;
   logic [XLEN-1:0] s1_imm;
   logic [XLEN-1:0] s1_pc;
   logic            s1_illegal;
   logic            s2_v;

   logic            s2_load;
   logic            s1_load;
   logic            in_fire;

   ysyx_25030081_imm_sel #(
      .XLEN    (XLEN),
      .SHAMT_W (SHAMT_W)
   ) u_imm_sel (
      .inst    (in_inst),
      .op      (in_op),
      .imm     (dec_imm),
      .illegal (dec_illegal)
   );

   // S2 frees up when empty or draining; S1 can then always move forward,
   // which lets a full pipe accept and emit in the same cycle.
   assign s2_load   = !s2_v || out_ready;
   assign s1_load   = !s1_v || s2_load;
   assign in_ready  = !flush && s1_load;
   assign in_fire   = in_valid && in_ready;
   assign out_valid = s2_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else if (flush) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else begin
         if (s2_load) s2_v <= s1_v;
         if (s1_load) s1_v <= in_fire;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_imm     <= '0;
         s1_pc      <= '0;
         s1_illegal <= 1'b0;
      end else if (in_fire) begin
         s1_imm     <= dec_imm;
         s1_pc      <= in_pc;
         s1_illegal <= dec_illegal;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_imm     <= '0;
         out_pc      <= '0;
         out_target  <= '0;
         out_illegal <= 1'b0;
      end else if (!flush && s2_load && s1_v) begin
         out_imm     <= s1_imm;
         out_pc      <= s1_pc;
         out_target  <= s1_pc + s1_imm;
         out_illegal <= s1_illegal;
      end
   end

endmodule
